// File: rtl/adc_delta_tracker_mc.sv
// Round-robin multi-channel delta-ADC tracker. Each channel has an adaptive step
// and saturating value arithmetic. One channel is served per sampling strobe.
module adc_delta_tracker_mc #(
  parameter int W         = 16,
  parameter int N         = 4,
  parameter int RUN_LEN   = 3,
  parameter int MAX_SHIFT = 4,
  localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   comparator_i,
  input  logic           sampling_strb,
  input  logic           adaptive_en,
  output logic [N*W-1:0] value_o,
  output logic           out_valid,
  output logic [CW-1:0]  out_chan,
  output logic [W-1:0]   out_value,
  output logic           out_sat
);

  localparam int SW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;
  localparam int RW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [W:0]   MAXV = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0] MID  = {1'b1, {(W-1){1'b0}}};

  logic [N-1:0]  comp_meta, comp_sync;
  logic [W-1:0]  value_r [N];
  logic [SW-1:0] shift_r [N];
  logic [RW-1:0] run_r   [N];
  logic [N-1:0]  last_dir;
  logic [CW-1:0] ptr;

  logic          d;
  logic [W:0]    cur, step, sum;
  logic [W-1:0]  nxt_value;
  logic          nxt_sat;
  logic [SW-1:0] nxt_shift;
  logic [RW-1:0] nxt_run;
  logic          nxt_dir;
  logic [CW-1:0] nxt_ptr;

  always_comb begin
    d         = comp_sync[ptr];
    cur       = {1'b0, value_r[ptr]};
    step      = (adaptive_en && (d == last_dir[ptr])) ? ((W+1)'(1) << shift_r[ptr]) : (W+1)'(1);
    sum       = '0;
    nxt_value = value_r[ptr];
    nxt_sat   = 1'b0;
    if (d) begin
      sum = cur + step;
      if (sum > MAXV) begin
        nxt_value = MAXV[W-1:0];
        nxt_sat   = 1'b1;
      end else begin
        nxt_value = sum[W-1:0];
      end
    end else if (cur < step) begin
      nxt_value = '0;
      nxt_sat   = 1'b1;
    end else begin
      sum       = cur - step;
      nxt_value = sum[W-1:0];
    end

    // With adaptation off the direction history is frozen, only the run/shift clear.
    nxt_shift = shift_r[ptr];
    nxt_run   = run_r[ptr];
    nxt_dir   = last_dir[ptr];
    if (!adaptive_en) begin
      nxt_shift = '0;
      nxt_run   = '0;
    end else if (d != last_dir[ptr]) begin
      nxt_shift = '0;
      nxt_run   = '0;
      nxt_dir   = d;
    end else if (run_r[ptr] == RW'(RUN_LEN - 1)) begin
      nxt_run = '0;
      if (shift_r[ptr] != SW'(MAX_SHIFT)) nxt_shift = shift_r[ptr] + 1'b1;
    end else begin
      nxt_run = run_r[ptr] + 1'b1;
    end

    nxt_ptr = (ptr == CW'(N - 1)) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      comp_meta <= '0;
      comp_sync <= '0;
      last_dir  <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_value <= '0;
      out_sat   <= 1'b0;
      for (int c = 0; c < N; c++) begin
        value_r[c] <= MID;
        shift_r[c] <= '0;
        run_r[c]   <= '0;
      end
    end else begin
      comp_meta <= comparator_i;
      comp_sync <= comp_meta;
      out_valid <= sampling_strb;
      if (sampling_strb) begin
        value_r[ptr]  <= nxt_value;
        shift_r[ptr]  <= nxt_shift;
        run_r[ptr]    <= nxt_run;
        last_dir[ptr] <= nxt_dir;
        ptr           <= nxt_ptr;
        out_chan      <= ptr;
        out_value     <= nxt_value;
        out_sat       <= nxt_sat;
      end
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_val
    assign value_o[c*W +: W] = value_r[c];
  end

endmodule

// File: tb/tb_adc_delta_tracker_mc.sv
// Bench for adc_delta_tracker_mc: per-cycle comparison against an arithmetic model
// for a 4x16 instance, plus directed literal checks including a 1x4 saturation instance.
module tb_adc_delta_tracker_mc;
  localparam int W = 16, N = 4, RL = 3, MS = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] comp;
  logic strobe, adapt;
  logic [N*W-1:0] value_o;
  logic out_valid, out_sat;
  logic [1:0] out_chan;
  logic [W-1:0] out_value;

  logic [0:0] s_comp;
  logic s_strobe, s_adapt;
  logic [3:0] s_value_o, s_out_value;
  logic s_valid, s_sat;
  logic [0:0] s_chan;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  adc_delta_tracker_mc #(.W(W), .N(N), .RUN_LEN(RL), .MAX_SHIFT(MS)) dut (
    .clk(clk), .reset(reset), .comparator_i(comp), .sampling_strb(strobe),
    .adaptive_en(adapt), .value_o(value_o), .out_valid(out_valid),
    .out_chan(out_chan), .out_value(out_value), .out_sat(out_sat));

  adc_delta_tracker_mc #(.W(4), .N(1), .RUN_LEN(3), .MAX_SHIFT(2)) dut_s (
    .clk(clk), .reset(reset), .comparator_i(s_comp), .sampling_strb(s_strobe),
    .adaptive_en(s_adapt), .value_o(s_value_o), .out_valid(s_valid),
    .out_chan(s_chan), .out_value(s_out_value), .out_sat(s_sat));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer arithmetic with explicit clamping.
  int mval[N], msh[N], mrun[N];
  bit mld[N];
  int mptr, mchan, mout;
  bit mvalid, msat, mstarted = 0;
  logic [N-1:0] h_a, h_b;

  always @(posedge clk) begin
    int c, step, t;
    bit d;
    mstarted = 1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mval[i] = 1 << (W - 1); msh[i] = 0; mrun[i] = 0; mld[i] = 0;
      end
      mptr = 0; mchan = 0; mout = 0; mvalid = 0; msat = 0; h_a = '0; h_b = '0;
    end else begin
      mvalid = strobe;
      if (strobe) begin
        c = mptr;
        d = h_b[c];
        step = (adapt && d == mld[c]) ? (1 << msh[c]) : 1;
        t = d ? mval[c] + step : mval[c] - step;
        msat = (t > MAXV) || (t < 0);
        mval[c] = (t > MAXV) ? MAXV : (t < 0) ? 0 : t;
        if (!adapt) begin
          msh[c] = 0; mrun[c] = 0;
        end else if (d != mld[c]) begin
          msh[c] = 0; mrun[c] = 0; mld[c] = d;
        end else if (mrun[c] == RL - 1) begin
          mrun[c] = 0; msh[c] = (msh[c] + 1 > MS) ? MS : msh[c] + 1;
        end else begin
          mrun[c] = mrun[c] + 1;
        end
        mchan = c; mout = mval[c];
        mptr = (mptr + 1) % N;
      end
      h_b = h_a;
      h_a = comp;
    end
  end

  always @(negedge clk) begin
    if (mstarted) begin
      for (int c = 0; c < N; c++)
        chk($sformatf("model_value_ch%0d", c), 64'(value_o[c*W +: W]), 64'(mval[c]));
      chk("model_out_valid", 64'(out_valid), 64'(mvalid));
      chk("model_out_chan", 64'(out_chan), 64'(mchan));
      chk("model_out_value", 64'(out_value), 64'(mout));
      chk("model_out_sat", 64'(out_sat), 64'(msat));
    end
  end

  logic [15:0] adapt_exp [8] = '{16'h8001, 16'h8002, 16'h8003, 16'h8004,
                                 16'h8006, 16'h8008, 16'h800A, 16'h800E};

  initial begin
    reset = 1; comp = '0; strobe = 0; adapt = 1;
    s_comp = '0; s_strobe = 0; s_adapt = 0;
    repeat (2) @(negedge clk);
    strobe = 1;
    @(negedge clk);
    chk("reset_strobe_no_valid", 64'(out_valid), 64'd0);
    chk("reset_midscale", value_o, {4{16'h8000}});
    reset = 0; strobe = 0;
    @(negedge clk);
    chk("post_reset_no_valid", 64'(out_valid), 64'd0);

    // round-robin
    comp = 4'hF;
    repeat (2) @(negedge clk);
    strobe = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rr_chan_%0d", i), 64'(out_chan), 64'(i % 4));
      chk("rr_valid", 64'(out_valid), 64'd1);
      if (i == 0) chk("rr_ch0_first", 64'(value_o[15:0]), 64'h8001);
      if (i == 4) chk("rr_ch0_second", 64'(value_o[15:0]), 64'h8002);
    end
    strobe = 0;
    @(negedge clk);
    chk("rr_valid_drop", 64'(out_valid), 64'd0);
    chk("rr_chan_hold", 64'(out_chan), 64'd0);

    // adaptive step growth on ch0
    reset = 1;
    @(negedge clk);
    reset = 0; comp = 4'b0001;
    repeat (2) @(negedge clk);
    strobe = 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i % 4 == 0) chk($sformatf("adapt_ch0_%0d", i / 4), 64'(value_o[15:0]), 64'(adapt_exp[i/4]));
    end
    strobe = 0;

    // direction change resets step
    comp = 4'b0000;
    repeat (2) @(negedge clk);
    strobe = 1;
    @(negedge clk);
    strobe = 0;
    chk("dir_change_ch0", 64'(value_o[15:0]), 64'h800D);
    chk("dir_change_sat", 64'(out_sat), 64'd0);
    chk("dir_change_chan", 64'(out_chan), 64'd0);

    // mixed pattern with adaptive_en toggling, checked by the model
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      comp   = 4'((i / 5) ^ (i / 7));
      strobe = (i % 3 != 2);
      adapt  = ((i / 16) % 2 == 0);
    end
    @(negedge clk);
    strobe = 0; adapt = 1;

    // synchroniser latency
    reset = 1; comp = '0;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    comp = 4'b0011;
    @(negedge clk);
    strobe = 1;
    @(negedge clk);
    chk("sync_old_bit_ch0", 64'(value_o[15:0]), 64'h7FFF);
    @(negedge clk);
    chk("sync_new_bit_ch1", 64'(value_o[31:16]), 64'h8001);
    @(negedge clk);
    chk("sync_ch2", 64'(value_o[47:32]), 64'h7FFF);
    strobe = 0;

    // reset mid-operation
    reset = 1;
    @(negedge clk);
    chk("midop_reset_values", value_o, {4{16'h8000}});
    chk("midop_reset_valid", 64'(out_valid), 64'd0);
    reset = 0;
    repeat (2) @(negedge clk);
    strobe = 1;
    @(negedge clk);
    strobe = 0;
    chk("midop_first_chan", 64'(out_chan), 64'd0);
    chk("midop_first_ch0", 64'(value_o[15:0]), 64'h8001);

    // saturation on the 4-bit single-channel instance
    s_comp = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      s_strobe = 1;
      @(negedge clk);
      s_strobe = 0;
      if (i == 6) begin
        chk("sat_up_land_value", 64'(s_value_o), 64'hF);
        chk("sat_up_land_flag", 64'(s_sat), 64'd0);
      end
      if (i == 7) begin
        chk("sat_up_clamp_value", 64'(s_out_value), 64'hF);
        chk("sat_up_clamp_flag", 64'(s_sat), 64'd1);
        chk("sat_up_valid", 64'(s_valid), 64'd1);
      end
    end
    s_comp = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      s_strobe = 1;
      @(negedge clk);
      s_strobe = 0;
      if (i == 14) begin
        chk("sat_dn_land_value", 64'(s_value_o), 64'h0);
        chk("sat_dn_land_flag", 64'(s_sat), 64'd0);
      end
      if (i == 15) begin
        chk("sat_dn_clamp_value", 64'(s_value_o), 64'h0);
        chk("sat_dn_clamp_flag", 64'(s_sat), 64'd1);
        chk("sat_dn_chan", 64'(s_chan), 64'd0);
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
